// File: rtl/gpi_rx_pkg.sv
// Shared types and limits for the GPI pad receiver.
package gpi_rx_pkg;

    localparam int unsigned SYNC_STAGES_MIN = 2;
    localparam int unsigned SYNC_STAGES_MAX = 4;

    typedef enum logic [1:0] {
        EDGE_NONE = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10,
        EDGE_BOTH = 2'b11
    } edge_sel_e;

    typedef enum logic [1:0] {
        OFF     = 2'b00,
        ARM     = 2'b01,
        STABLE  = 2'b10,
        QUALIFY = 2'b11
    } rx_state_e;

endpackage

// File: rtl/gpi_rx_sync.sv
// Multi-stage synchronizer for the asynchronous pad level, with a synchronous flush.
module gpi_rx_sync #(
    parameter int unsigned STAGES    = 2,
    parameter logic        RESET_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic d_i,
    input  logic flush_i,
    output logic q_o
);

    logic [STAGES-1:0] chain_q;

    // Shift the pad level through the chain; flush parks every stage at the idle level.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            chain_q <= {STAGES{RESET_VAL}};
        end else if (flush_i) begin
            chain_q <= {STAGES{RESET_VAL}};
        end else begin
            chain_q <= {chain_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/gpi_pad_receiver.sv
// Receive-side conditioning of a pad DI level: synchronizer, glitch filter, edge detect
// and sticky event/overrun flags. Define GPI_RX_FILTER_EN to build the glitch filter;
// without it the synchronized level is passed straight to di_o once armed.
module gpi_pad_receiver
    import gpi_rx_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_W      = 8,
    parameter logic        RESET_VAL   = 1'b0
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              pad_di_i,
    input  logic              en_i,
    input  logic [FILT_W-1:0] filt_th_i,
    input  logic [1:0]        edge_sel_i,
    input  logic              evt_ack_i,
    output logic              ie_o,
    output logic              di_o,
    output logic              edge_o,
    output logic              evt_o,
    output logic              ovf_o
);

    localparam int unsigned ARM_W = $clog2(SYNC_STAGES_MAX + 1);

    rx_state_e        state_q, state_d;
    logic [ARM_W-1:0] arm_q, arm_d;
    logic             sync_lvl;
    logic             di_d, edge_d, evt_d, ovf_d;
    logic             rise_hit, fall_hit, edge_hit;
    edge_sel_e        sel;

`ifdef GPI_RX_FILTER_EN
    logic [FILT_W-1:0] cnt_q, cnt_d;
`else
    logic th_unused;
    assign th_unused = ^filt_th_i;
`endif

    // Synchronizer is held at the idle level whenever the receiver is disabled.
    gpi_rx_sync #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (RESET_VAL)
    ) u_sync (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .d_i     (pad_di_i),
        .flush_i (!en_i),
        .q_o     (sync_lvl)
    );

    assign sel      = edge_sel_e'(edge_sel_i);
    assign rise_hit = sync_lvl & ~di_o & ((sel == EDGE_RISE) || (sel == EDGE_BOTH));
    assign fall_hit = ~sync_lvl & di_o & ((sel == EDGE_FALL) || (sel == EDGE_BOTH));
    assign edge_hit = rise_hit | fall_hit;

    // Next-state, filtered level and edge decision.
    always_comb begin
        state_d = state_q;
        arm_d   = arm_q;
        di_d    = di_o;
        edge_d  = 1'b0;
`ifdef GPI_RX_FILTER_EN
        cnt_d   = cnt_q;
`endif
        if (!en_i) begin
            state_d = OFF;
            arm_d   = '0;
            di_d    = RESET_VAL;
`ifdef GPI_RX_FILTER_EN
            cnt_d   = '0;
`endif
        end else begin
            case (state_q)
                OFF: begin
                    state_d = ARM;
                    arm_d   = '0;
                end
                ARM: begin
                    // Wait out the synchronizer fill so enabling never fakes an edge.
                    if (arm_q == ARM_W'(SYNC_STAGES)) begin
                        di_d    = sync_lvl;
                        state_d = STABLE;
                    end else begin
                        arm_d = arm_q + 1'b1;
                    end
                end
                STABLE: begin
                    if (sync_lvl != di_o) begin
`ifdef GPI_RX_FILTER_EN
                        state_d = QUALIFY;
                        cnt_d   = '0;
`else
                        di_d    = sync_lvl;
                        edge_d  = edge_hit;
`endif
                    end
                end
                QUALIFY: begin
`ifdef GPI_RX_FILTER_EN
                    if (sync_lvl == di_o) begin
                        state_d = STABLE;
                        cnt_d   = '0;
                    end else if (cnt_q >= filt_th_i) begin
                        di_d    = sync_lvl;
                        edge_d  = edge_hit;
                        cnt_d   = '0;
                        state_d = STABLE;
                    end else if (cnt_q != '1) begin
                        cnt_d = cnt_q + 1'b1;
                    end
`else
                    state_d = STABLE;
`endif
                end
                default: state_d = OFF;
            endcase
        end
    end

    // Sticky flags follow the registered edge pulse; a coincident set beats the ack.
    always_comb begin
        evt_d = evt_o;
        ovf_d = ovf_o;
        if (edge_o) begin
            evt_d = 1'b1;
            ovf_d = evt_ack_i ? 1'b0 : (ovf_o | evt_o);
        end else if (evt_ack_i) begin
            evt_d = 1'b0;
            ovf_d = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= OFF;
            arm_q   <= '0;
            ie_o    <= 1'b0;
            di_o    <= RESET_VAL;
            edge_o  <= 1'b0;
            evt_o   <= 1'b0;
            ovf_o   <= 1'b0;
        end else begin
            state_q <= state_d;
            arm_q   <= arm_d;
            ie_o    <= en_i;
            di_o    <= di_d;
            edge_o  <= edge_d;
            evt_o   <= evt_d;
            ovf_o   <= ovf_d;
        end
    end

`ifdef GPI_RX_FILTER_EN
    // Qualification counter.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_gpi_pad_receiver.sv
// Scoreboard bench for gpi_pad_receiver: directed scenarios plus randomized pad traffic,
// checked against a run-length reference model.
module tb_gpi_pad_receiver;

    localparam int unsigned SYNC   = 2;
    localparam int unsigned FILT_W = 8;
    localparam bit          RV     = 1'b0;
`ifdef GPI_RX_FILTER_EN
    localparam int FILT_ON = 1;
`else
    localparam int FILT_ON = 0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              pad, en, ack;
    logic [FILT_W-1:0] th;
    logic [1:0]        sel;
    logic              ie_o, di_o, edge_o, evt_o, ovf_o;

    gpi_pad_receiver #(
        .SYNC_STAGES (SYNC),
        .FILT_W      (FILT_W),
        .RESET_VAL   (RV)
    ) dut (
        .clk_i      (clk),
        .rstn_i     (rst_n),
        .pad_di_i   (pad),
        .en_i       (en),
        .filt_th_i  (th),
        .edge_sel_i (sel),
        .evt_ack_i  (ack),
        .ie_o       (ie_o),
        .di_o       (di_o),
        .edge_o     (edge_o),
        .evt_o      (evt_o),
        .ovf_o      (ovf_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic ie;
        logic di;
        logic edg;
        logic evt;
        logic ovf;
    } lvl_t;

    lvl_t lvl_q[$];
    int   edge_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   edge_seen = 0;

    // reference model state
    bit   m_ie, m_di, m_edge, m_evt, m_ovf;
    bit   m_sync[$];
    int   m_age, m_run;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_ie = 1'b0; m_di = RV; m_edge = 1'b0; m_evt = 1'b0; m_ovf = 1'b0;
        m_sync.delete();
        repeat (SYNC) m_sync.push_back(RV);
        m_age = 0;
        m_run = 0;
    endtask

    // One clock of behaviour: the pad must disagree with di for th+2 consecutive
    // synchronized samples (or 1 without the filter) before di follows.
    task automatic model_step();
        bit s, nedge;
        int need;
        cyc++;
        if (m_edge) begin
            m_ovf = ack ? 1'b0 : (m_ovf | m_evt);
            m_evt = 1'b1;
        end else if (ack) begin
            m_evt = 1'b0;
            m_ovf = 1'b0;
        end
        s = m_sync[0];
        nedge = 1'b0;
        if (!en) begin
            m_age = 0;
            m_run = 0;
            m_di  = RV;
            m_sync.delete();
            repeat (SYNC) m_sync.push_back(RV);
        end else begin
            if (m_age < int'(SYNC) + 3) m_age++;
            if (m_age == int'(SYNC) + 2) begin
                m_di  = s;
                m_run = 0;
            end else if (m_age > int'(SYNC) + 2) begin
                if (s != m_di) begin
                    m_run++;
                    need = FILT_ON ? int'(th) + 2 : 1;
                    if (m_run >= need) begin
                        nedge = (s && sel[0]) || (!s && sel[1]);
                        m_di  = s;
                        m_run = 0;
                    end
                end else begin
                    m_run = 0;
                end
            end
            void'(m_sync.pop_front());
            m_sync.push_back(pad);
        end
        m_edge = nedge;
        m_ie   = en;
        if (nedge) edge_q.push_back(cyc);
        lvl_q.push_back('{ie: m_ie, di: m_di, edg: m_edge, evt: m_evt, ovf: m_ovf});
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) cycle();
    endtask

    task automatic ack_pulse();
        ack = 1'b1;
        cycle();
        ack = 1'b0;
    endtask

    // Monitor: compares every presented cycle and pops the edge scoreboard on each pulse.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (lvl_q.size() != 0) begin
                lvl_t e;
                e = lvl_q.pop_front();
                chk("ie_o", 32'(ie_o), 32'(e.ie));
                chk("di_o", 32'(di_o), 32'(e.di));
                chk("edge_o", 32'(edge_o), 32'(e.edg));
                chk("evt_o", 32'(evt_o), 32'(e.evt));
                chk("ovf_o", 32'(ovf_o), 32'(e.ovf));
            end
            if (edge_o === 1'b1) begin
                edge_seen++;
                if (edge_q.size() == 0) chk("edge_unexpected", 32'd1, 32'd0);
                else chk("edge_cycle", 32'(cyc), 32'(edge_q.pop_front()));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, pass_len, es;
        lat      = FILT_ON ? int'(SYNC) + 3 + 2 : int'(SYNC) + 1;
        pass_len = FILT_ON ? 3 + 2 : 1;

        rst_n = 1'b0; en = 1'b0; pad = 1'b0; ack = 1'b0; th = FILT_W'(3); sel = 2'b11;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_ie", 32'(ie_o), 32'd0);
        chk("rst_di", 32'(di_o), 32'(RV));
        chk("rst_edge", 32'(edge_o), 32'd0);
        chk("rst_evt", 32'(evt_o), 32'd0);
        chk("rst_ovf", 32'(ovf_o), 32'd0);
        rst_n = 1'b1;
        wait_cycles(2);

        // 1: enable with pad already high; arm period swallows the level change
        en = 1'b1; pad = 1'b1;
        cycle();
        chk("t1_ie", 32'(ie_o), 32'd1);
        wait_cycles(2);
        chk("t1_di_arming", 32'(di_o), 32'd0);
        cycle();
        chk("t1_di_loaded", 32'(di_o), 32'd1);
        wait_cycles(5);
        chk("t1_no_edge", 32'(edge_seen), 32'd0);
        chk("t1_no_evt", 32'(evt_o), 32'd0);

        // 2: clean rising edge latency
        pad = 1'b0;
        wait_cycles(12);
        ack_pulse();
        wait_cycles(2);
        es = edge_seen;
        pad = 1'b1;
        wait_cycles(lat - 1);
        chk("t2_di_before", 32'(di_o), 32'd0);
        cycle();
        chk("t2_di_at_lat", 32'(di_o), 32'd1);
        chk("t2_edge_at_lat", 32'(edge_o), 32'd1);
        wait_cycles(3);
        chk("t2_one_edge", 32'(edge_seen), 32'(es + 1));
        chk("t2_evt", 32'(evt_o), 32'd1);

        // 3: glitch rejection around the threshold boundary
        pad = 1'b0;
        wait_cycles(12);
        ack_pulse();
        for (int len = 3; len <= 5; len++) begin
            es = edge_seen;
            pad = 1'b1;
            wait_cycles(len);
            pad = 1'b0;
            wait_cycles(14);
            chk("t3_glitch_edges", 32'(edge_seen - es), (len >= pass_len) ? 32'd2 : 32'd0);
            chk("t3_glitch_di", 32'(di_o), 32'd0);
        end

        // 4: rise-only selection
        sel = 2'b01;
        ack_pulse();
        es = edge_seen;
        pad = 1'b1;
        wait_cycles(12);
        pad = 1'b0;
        wait_cycles(12);
        chk("t4_rise_only", 32'(edge_seen), 32'(es + 1));

        // 5: overrun, then ack coincident with an edge
        sel = 2'b11;
        ack_pulse();
        pad = 1'b1;
        wait_cycles(12);
        chk("t5_evt", 32'(evt_o), 32'd1);
        chk("t5_no_ovf", 32'(ovf_o), 32'd0);
        pad = 1'b0;
        wait_cycles(12);
        chk("t5_ovf", 32'(ovf_o), 32'd1);
        pad = 1'b1;
        wait_cycles(lat);
        chk("t5_edge_now", 32'(edge_o), 32'd1);
        ack_pulse();
        chk("t5_ack_evt", 32'(evt_o), 32'd1);
        chk("t5_ack_ovf", 32'(ovf_o), 32'd0);

        // 6: disable while a falling edge is still qualifying
        wait_cycles(4);
        pad = 1'b0;
        wait_cycles(lat - 2);
        chk("t6_di_held", 32'(di_o), 32'd1);
        en = 1'b0;
        cycle();
        chk("t6_di_off", 32'(di_o), 32'(RV));
        chk("t6_ie_off", 32'(ie_o), 32'd0);
        chk("t6_evt_kept", 32'(evt_o), 32'd1);
        en = 1'b1;
        wait_cycles(8);

        // randomized traffic, with an asynchronous reset in the middle
        for (int i = 0; i < 1500; i++) begin
            if (i == 800) begin
                #2 rst_n = 1'b0;
                #1;
                chk("arst_ie", 32'(ie_o), 32'd0);
                chk("arst_di", 32'(di_o), 32'(RV));
                chk("arst_edge", 32'(edge_o), 32'd0);
                chk("arst_evt", 32'(evt_o), 32'd0);
                chk("arst_ovf", 32'(ovf_o), 32'd0);
                model_reset();
                lvl_q.delete();
                edge_q.delete();
                @(negedge clk);
                rst_n = 1'b1;
            end
            if ($urandom_range(0, 5) == 0) pad = ~pad;
            if ($urandom_range(0, 49) == 0) th = FILT_W'($urandom_range(0, 4));
            if ($urandom_range(0, 99) == 0) sel = 2'($urandom_range(0, 3));
            ack = ($urandom_range(0, 15) == 0);
            en  = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
            cycle();
        end
        ack = 1'b0;
        wait_cycles(3);
        #1;
        chk("edge_q_drained", 32'(edge_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
